agc_loop_ctrl: RTL and testbench
================================

Name: agc_loop_ctrl

Overview:
- Closed-loop controller for one channel's AGC DSP and saturate/scale stage.
- Integrates the symmetric gt/lt flags, 8 samples per clock, over a fixed window.
- At window end, computes a new gain from gt+lt and a new DC offset from gt−lt, then hands both to the DSP coefficient loader over a valid/ready handshake.
- Raw counts are exported for software monitoring.

Parameters:
- NSAMP, 8, samples (gt/lt flag pairs) per clock.
- PERIOD_LOG2, 16, integration window length = 2^PERIOD_LOG2 clocks.
- CNT_W, PERIOD_LOG2+$clog2(NSAMP)+1, counter width; holds NSAMP·2^PERIOD_LOG2 without overflow.
- TARGET, 32000, desired gt+lt count per window.
- GAIN_W, 18, unsigned gain coefficient width.
- GAIN_INIT, 4096, gain value after reset.
- OFS_W, 18, signed offset coefficient width.
- GAIN_SHIFT, 4, right-shift applied to gain error.
- OFS_SHIFT, 4, right-shift applied to offset error.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- enable_i  in  1  loop run enable
- gt_i  in  NSAMP  per-sample "greater than" flags
- lt_i  in  NSAMP  per-sample "less than" flags
- sw_wr_i  in  1  software coefficient write strobe (honoured in IDLE only)
- sw_gain_i  in  GAIN_W  software gain value
- sw_offset_i  in  OFS_W  software offset value
- gain_o  out  GAIN_W  current gain coefficient
- offset_o  out  OFS_W  current offset coefficient (two's complement)
- load_valid_o  out  1  coefficients pending for DSP loader
- load_ready_i  in  1  loader accepts coefficients
- gt_count_o  out  CNT_W  last completed window gt count
- lt_count_o  out  CNT_W  last completed window lt count
- count_valid_o  out  1  one-cycle pulse when counts update

Behaviour:
- Reset values (asynchronous on rst_i): state=IDLE, counters=0, gain_o=GAIN_INIT, offset_o=0, load_valid_o=0, gt_count_o=lt_count_o=0, count_valid_o=0.
- States: IDLE, ACCUM, CALC, APPLY, LOAD.
- IDLE:
  - enable_i=1 → ACCUM with counters and window timer cleared.
  - sw_wr_i=1 → gain_o/offset_o load sw values next cycle, then → LOAD so the loader receives them.
  - If sw_wr_i and enable_i are both high, sw_wr_i wins.
- ACCUM:
  - Each clock, gt_acc += popcount(gt_i) and lt_acc += popcount(lt_i).
  - A sample with both flags set counts in both (illegal upstream, but not masked).
  - The timer runs 2^PERIOD_LOG2 clocks; the last accumulating clock is cycle 2^PERIOD_LOG2−1, then → CALC.
  - enable_i=0 mid-window → IDLE; partial counts are discarded; gain/offset are unchanged; no count_valid_o.
- CALC (1 clk):
  - gt_count_o/lt_count_o ← accumulators; count_valid_o=1 for this cycle.
  - gerr = (gt+lt) − TARGET, signed CNT_W+1.
  - oerr = gt − lt, signed CNT_W+1.
- APPLY (1 clk):
  - gain_o ← clamp(gain_o − (gerr >>> GAIN_SHIFT), 0, 2^GAIN_W−1).
  - offset_o ← clamp(offset_o − (oerr >>> OFS_SHIFT), −2^(OFS_W−1), 2^(OFS_W−1)−1).
  - Shifts are arithmetic (round toward −∞).
  - Intermediate values are computed at max(GAIN_W, CNT_W)+2 bits so no wrap occurs before clamping.
  - → LOAD.
- LOAD:
  - load_valid_o=1; gain_o/offset_o held stable.
  - On load_valid_o & load_ready_i: load_valid_o drops next cycle, then → ACCUM (counters cleared) if enable_i=1, else → IDLE.
  - enable_i deasserted during LOAD does not abort the handshake.
- Flags arriving during CALC/APPLY/LOAD are ignored (dead time of 2 clocks + handshake).
- Latency: coefficients are valid (load_valid_o) 3 clocks after the last accumulating clock when load_ready_i is tied high.
- rst_i mid-operation returns everything to reset values immediately; a pending load is dropped.

Decomposition:
- Package agc_ctrl_pkg holds:
  - state enum (IDLE/ACCUM/CALC/APPLY/LOAD);
  - function popcount(NSAMP);
  - clamp functions for unsigned gain and signed offset.
- Sub-module agc_flag_counter: popcount + accumulate with clear and enable; instanced twice (gt, lt).
- FSM and arithmetic live in agc_loop_ctrl.

Test Plan:
- Config for all tests: PERIOD_LOG2=4, TARGET=16, GAIN_SHIFT=2, OFS_SHIFT=1.
- gt_i=8'hFF, lt_i=0 for a full window, ready=1 → gt_count_o=128, lt_count_o=0, count_valid_o pulse; gain_o 4096→4068; offset_o 0→−64.
- gt_i=lt_i=8'h01 each clock → counts 16/16, gerr=16 → gain 4092, offset unchanged 0.
- gt_i=lt_i=0, TARGET=16, gain_o preset 2^GAIN_W−2 via sw_wr_i → gain clamps at 262143, no wrap.
- load_ready_i held low 10 clks after APPLY → load_valid_o stays high, gain_o stable; next window starts 1 clk after ready rises.
- enable_i dropped at window clock 7 → IDLE, no count_valid_o, gain/offset unchanged; rst_i asserted during LOAD → load_valid_o=0, gain_o=4096 immediately.

Source files
------------

// File: rtl/agc_ctrl_pkg.sv
// Shared types and helpers for the AGC loop controller: FSM states,
// flag popcount and the gain/offset saturation functions.
package agc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_CALC,
        ST_APPLY,
        ST_LOAD
    } state_e;

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < 64; i++) begin
            c += {31'd0, v[i]};
        end
        return c;
    endfunction

    // Saturate to the unsigned range [0, 2^w-1].
    function automatic longint clamp_gain(input longint v, input int unsigned w);
        longint hi;
        hi = (longint'(1) << w) - 1;
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Saturate to the two's complement range [-2^(w-1), 2^(w-1)-1].
    function automatic longint clamp_ofs(input longint v, input int unsigned w);
        longint hi;
        longint lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/agc_flag_counter.sv
// Per-clock popcount of a flag vector accumulated into a window counter.
// Clear has priority over enable.
module agc_flag_counter
    import agc_ctrl_pkg::*;
#(
    parameter int unsigned NSAMP = 8,
    parameter int unsigned CNT_W = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [NSAMP-1:0] flags_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] acc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q + CNT_W'(popcount(64'(flags_i)));
        end
    end

    assign count_o = acc_q;

endmodule

// File: rtl/agc_loop_ctrl.sv
// Closed-loop AGC controller: integrates gt/lt flags over a window, derives
// new gain/offset coefficients and hands them to the DSP loader.
module agc_loop_ctrl
    import agc_ctrl_pkg::*;
#(
    parameter int unsigned NSAMP       = 8,
    parameter int unsigned PERIOD_LOG2 = 16,
    parameter int unsigned CNT_W       = PERIOD_LOG2 + $clog2(NSAMP) + 1,
    parameter int unsigned TARGET      = 32000,
    parameter int unsigned GAIN_W      = 18,
    parameter int unsigned GAIN_INIT   = 4096,
    parameter int unsigned OFS_W       = 18,
    parameter int unsigned GAIN_SHIFT  = 4,
    parameter int unsigned OFS_SHIFT   = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [NSAMP-1:0]  gt_i,
    input  logic [NSAMP-1:0]  lt_i,
    input  logic              sw_wr_i,
    input  logic [GAIN_W-1:0] sw_gain_i,
    input  logic [OFS_W-1:0]  sw_offset_i,
    output logic [GAIN_W-1:0] gain_o,
    output logic [OFS_W-1:0]  offset_o,
    output logic              load_valid_o,
    input  logic              load_ready_i,
    output logic [CNT_W-1:0]  gt_count_o,
    output logic [CNT_W-1:0]  lt_count_o,
    output logic              count_valid_o
);

    localparam int unsigned MW = (GAIN_W > CNT_W) ? GAIN_W : CNT_W;
    localparam int unsigned IW = ((OFS_W > MW) ? OFS_W : MW) + 2;

    state_e                   state_q;
    logic [PERIOD_LOG2-1:0]   timer_q;
    logic [GAIN_W-1:0]        gain_q, gain_d;
    logic signed [OFS_W-1:0]  offset_q, offset_d;
    logic signed [CNT_W:0]    gerr_q, gerr_d, oerr_q, oerr_d;
    logic [CNT_W-1:0]         gt_cnt_q, lt_cnt_q;
    logic                     load_valid_q, count_valid_q;
    logic [CNT_W-1:0]         gt_acc, lt_acc;
    logic                     acc_clr, acc_en;
    logic signed [IW-1:0]     gt_w, lt_w, gain_new, ofs_new;

    // Counters sit cleared outside ACCUM, so every window starts from zero.
    assign acc_clr = (state_q != ST_ACCUM);
    assign acc_en  = (state_q == ST_ACCUM);

    agc_flag_counter #(.NSAMP(NSAMP), .CNT_W(CNT_W)) u_gt_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (acc_clr),
        .en_i    (acc_en),
        .flags_i (gt_i),
        .count_o (gt_acc)
    );

    agc_flag_counter #(.NSAMP(NSAMP), .CNT_W(CNT_W)) u_lt_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (acc_clr),
        .en_i    (acc_en),
        .flags_i (lt_i),
        .count_o (lt_acc)
    );

    always_comb begin
        gt_w     = IW'(gt_acc);
        lt_w     = IW'(lt_acc);
        gerr_d   = (CNT_W + 1)'(gt_w + lt_w - signed'(IW'(TARGET)));
        oerr_d   = (CNT_W + 1)'(gt_w - lt_w);
        gain_new = signed'(IW'(gain_q)) - (IW'(gerr_q) >>> GAIN_SHIFT);
        ofs_new  = IW'(offset_q) - (IW'(oerr_q) >>> OFS_SHIFT);
        gain_d   = GAIN_W'(clamp_gain(longint'(gain_new), GAIN_W));
        offset_d = OFS_W'(clamp_ofs(longint'(ofs_new), OFS_W));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            gain_q        <= GAIN_W'(GAIN_INIT);
            offset_q      <= '0;
            gerr_q        <= '0;
            oerr_q        <= '0;
            gt_cnt_q      <= '0;
            lt_cnt_q      <= '0;
            load_valid_q  <= 1'b0;
            count_valid_q <= 1'b0;
        end else begin
            count_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sw_wr_i) begin
                        gain_q       <= sw_gain_i;
                        offset_q     <= signed'(sw_offset_i);
                        load_valid_q <= 1'b1;
                        state_q      <= ST_LOAD;
                    end else if (enable_i) begin
                        timer_q <= '0;
                        state_q <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (!enable_i) begin
                        state_q <= ST_IDLE;
                    end else if (timer_q == '1) begin
                        state_q <= ST_CALC;
                    end else begin
                        timer_q <= timer_q + PERIOD_LOG2'(1);
                    end
                end
                ST_CALC: begin
                    gt_cnt_q      <= gt_acc;
                    lt_cnt_q      <= lt_acc;
                    count_valid_q <= 1'b1;
                    gerr_q        <= gerr_d;
                    oerr_q        <= oerr_d;
                    state_q       <= ST_APPLY;
                end
                ST_APPLY: begin
                    gain_q       <= gain_d;
                    offset_q     <= offset_d;
                    load_valid_q <= 1'b1;
                    state_q      <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (load_ready_i) begin
                        load_valid_q <= 1'b0;
                        timer_q      <= '0;
                        state_q      <= enable_i ? ST_ACCUM : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gain_o        = gain_q;
    assign offset_o      = offset_q;
    assign load_valid_o  = load_valid_q;
    assign gt_count_o    = gt_cnt_q;
    assign lt_count_o    = lt_cnt_q;
    assign count_valid_o = count_valid_q;

endmodule

// File: tb/tb_agc_loop_ctrl.sv
// Directed bench for agc_loop_ctrl with a 16-clock window, TARGET=16,
// GAIN_SHIFT=2, OFS_SHIFT=1; expected values are hand-computed.
module tb_agc_loop_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  gt;
    logic [7:0]  lt;
    logic        sw_wr;
    logic [17:0] sw_gain;
    logic [17:0] sw_ofs;
    logic [17:0] gain;
    logic [17:0] offset;
    logic        lv;
    logic        ready;
    logic [7:0]  gt_cnt;
    logic [7:0]  lt_cnt;
    logic        cv;

    int checks = 0;
    int errors = 0;
    logic cv_seen;

    agc_loop_ctrl #(
        .PERIOD_LOG2 (4),
        .TARGET      (16),
        .GAIN_SHIFT  (2),
        .OFS_SHIFT   (1)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (en),
        .gt_i          (gt),
        .lt_i          (lt),
        .sw_wr_i       (sw_wr),
        .sw_gain_i     (sw_gain),
        .sw_offset_i   (sw_ofs),
        .gain_o        (gain),
        .offset_o      (offset),
        .load_valid_o  (lv),
        .load_ready_i  (ready),
        .gt_count_o    (gt_cnt),
        .lt_count_o    (lt_cnt),
        .count_valid_o (cv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; gt = '0; lt = '0;
        sw_wr = 1'b0; sw_gain = '0; sw_ofs = '0; ready = 1'b1;
        tick(); tick();
        chk("rst_gain",   32'(gain),   32'd4096);
        chk("rst_offset", 32'(offset), 32'd0);
        chk("rst_lv",     32'(lv),     32'd0);
        chk("rst_gtcnt",  32'(gt_cnt), 32'd0);
        chk("rst_ltcnt",  32'(lt_cnt), 32'd0);
        chk("rst_cv",     32'(cv),     32'd0);
        rst = 1'b0;

        // Full window of all-gt flags: 128/0 -> gain 4068, offset -64
        gt = 8'hFF; en = 1'b1;
        tick();
        repeat (16) tick();
        chk("t1_calc_cv", 32'(cv), 32'd0);
        tick();
        chk("t1_cv",      32'(cv),     32'd1);
        chk("t1_gtcnt",   32'(gt_cnt), 32'd128);
        chk("t1_ltcnt",   32'(lt_cnt), 32'd0);
        chk("t1_lv_early", 32'(lv),    32'd0);
        tick();
        chk("t1_lv",      32'(lv),     32'd1);
        chk("t1_cv_off",  32'(cv),     32'd0);
        chk("t1_gain",    32'(gain),   32'd4068);
        chk("t1_offset",  32'(offset), 32'h3FFC0);
        en = 1'b0;
        tick();
        chk("t1_lv_drop", 32'(lv),     32'd0);
        pulse_reset();

        // Balanced single flags: 16/16 -> gain 4092, offset 0
        gt = 8'h01; lt = 8'h01; en = 1'b1;
        tick();
        repeat (16) tick();
        tick();
        chk("t2_gtcnt",   32'(gt_cnt), 32'd16);
        chk("t2_ltcnt",   32'(lt_cnt), 32'd16);
        tick();
        chk("t2_gain",    32'(gain),   32'd4092);
        chk("t2_offset",  32'(offset), 32'd0);
        en = 1'b0;
        tick();
        pulse_reset();

        // Software write (wins over enable), then gain saturates high
        gt = '0; lt = '0; en = 1'b1; sw_wr = 1'b1; sw_gain = 18'd262142; ready = 1'b0;
        tick();
        chk("t3_sw_lv",   32'(lv),     32'd1);
        chk("t3_sw_gain", 32'(gain),   32'd262142);
        sw_wr = 1'b0; ready = 1'b1;
        tick();
        chk("t3_hs_lv",   32'(lv),     32'd0);
        ready = 1'b0;
        repeat (16) tick();
        tick();
        chk("t3_cv",      32'(cv),     32'd1);
        chk("t3_gtcnt",   32'(gt_cnt), 32'd0);
        tick();
        chk("t3_lv",      32'(lv),     32'd1);
        chk("t3_gain",    32'(gain),   32'd262143);
        chk("t3_offset",  32'(offset), 32'd0);

        // Loader stalls 10 clocks; next window starts 1 clk after ready
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_lv_hold",   32'(lv),   32'd1);
            chk("t4_gain_hold", 32'(gain), 32'd262143);
        end
        gt = 8'h03; lt = 8'h03; ready = 1'b1;
        tick();
        chk("t4_lv_drop", 32'(lv), 32'd0);
        repeat (16) tick();
        tick();
        chk("t4_cv",      32'(cv),     32'd1);
        chk("t4_gtcnt",   32'(gt_cnt), 32'd32);
        chk("t4_ltcnt",   32'(lt_cnt), 32'd32);
        tick();
        chk("t4_gain",    32'(gain),   32'd262131);
        chk("t4_offset",  32'(offset), 32'd0);
        en = 1'b0;
        tick();
        pulse_reset();

        // Enable dropped at window clock 7: discard, no count_valid
        gt = 8'hFF; lt = '0; en = 1'b1;
        tick();
        repeat (7) tick();
        en = 1'b0;
        cv_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cv) cv_seen = 1'b1;
        end
        chk("t5_no_cv",   32'(cv_seen), 32'd0);
        chk("t5_lv",      32'(lv),      32'd0);
        chk("t5_gain",    32'(gain),    32'd4096);
        chk("t5_offset",  32'(offset),  32'd0);
        chk("t5_gtcnt",   32'(gt_cnt),  32'd0);

        // Reset during a stalled load drops it immediately
        en = 1'b1; ready = 1'b0;
        tick();
        repeat (16) tick();
        tick();
        tick();
        chk("t6_lv",      32'(lv),     32'd1);
        chk("t6_gain",    32'(gain),   32'd4068);
        rst = 1'b1;
        #1;
        chk("t6_rst_lv",     32'(lv),     32'd0);
        chk("t6_rst_gain",   32'(gain),   32'd4096);
        chk("t6_rst_offset", 32'(offset), 32'd0);
        tick();
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
